wb_queue: RTL and testbench

- Write-side initiator for the 3-port register file (32x32, x0 hard-wired to zero).
- Buffers register writebacks from the ALU and the load unit, and drains one write per cycle onto the register-file write port (we/a3/wd3).
- Provides per-read-port bypass so that reads of a register with a pending write return the newest value.
- Sits between the execute/memory stages and the register file in the datapath.

---
 rtl/wb_queue_if.sv | 37 +++
 rtl/wb_queue.sv | 127 ++++++++++++
 tb/tb_wb_queue.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
// Bus bundle for wb_queue: ALU/load writeback requests, register-file write port,
// bypass lookup and occupancy. The queue is the slave; the pipeline/bench is the master.
interface wb_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_data;
  logic          we;
  logic [4:0]    a3;
  logic [31:0]   wd3;
  logic [4:0]    a1;
  logic [4:0]    a2;
  logic          fwd1_hit;
  logic          fwd2_hit;
  logic [31:0]   fwd1_data;
  logic [31:0]   fwd2_data;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, a1, a2,
    input  alu_ready, ld_ready, we, a3, wd3, fwd1_hit, fwd2_hit,
           fwd1_data, fwd2_data, count, empty
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, a1, a2,
    output alu_ready, ld_ready, we, a3, wd3, fwd1_hit, fwd2_hit,
           fwd1_data, fwd2_data, count, empty
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue in front of the 32x32 register file: buffers ALU/load writes, drains one
// per cycle onto we/a3/wd3, and bypasses pending values to the read ports. WBQ_STATS_EN adds stat ports.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  wb_queue_if.slave         bus
`ifdef WBQ_STATS_EN
  ,
  output logic [31:0]       stat_stall,
  output logic [$clog2(DEPTH):0] stat_hwm
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] head, tail, alu_slot, idx;
  logic [CW-1:0] cnt, cnt_next;
  logic          push_ld, push_alu, pop;
  logic          we_r;
  logic [4:0]    a3_r;
  logic [31:0]   wd3_r;
  logic          h1, h2;
  logic [31:0]   d1, d2;

  // Readiness looks only at occupancy at the start of the cycle; a same-cycle pop frees nothing.
  assign bus.ld_ready  = !reset && (cnt < CW'(DEPTH));
  assign bus.alu_ready = !reset && (cnt < CW'(DEPTH - 1));

  assign push_ld  = bus.ld_valid  && bus.ld_ready  && (bus.ld_rd  != '0);
  assign push_alu = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
  assign pop      = (cnt != '0);
  assign alu_slot = tail + AW'(push_ld);
  assign cnt_next = cnt + CW'(push_ld) + CW'(push_alu) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push_ld) begin
      q_rd[tail]   <= bus.ld_rd;
      q_data[tail] <= bus.ld_data;
    end
    if (push_alu) begin
      q_rd[alu_slot]   <= bus.alu_rd;
      q_data[alu_slot] <= bus.alu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      we_r  <= 1'b0;
      a3_r  <= '0;
      wd3_r <= '0;
    end else begin
      tail <= tail + AW'(push_ld) + AW'(push_alu);
      cnt  <= cnt_next;
      we_r <= pop;
      if (pop) begin
        a3_r  <= q_rd[head];
        wd3_r <= q_data[head];
        head  <= head + AW'(1);
      end
    end
  end

  // Walk oldest to youngest (write register, head..tail) so later matches overwrite earlier ones.
  always_comb begin
    h1  = 1'b0;
    h2  = 1'b0;
    d1  = '0;
    d2  = '0;
    idx = '0;
    if (we_r && (a3_r == bus.a1)) begin
      h1 = 1'b1;
      d1 = wd3_r;
    end
    if (we_r && (a3_r == bus.a2)) begin
      h2 = 1'b1;
      d2 = wd3_r;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < cnt) begin
        if (q_rd[idx] == bus.a1) begin
          h1 = 1'b1;
          d1 = q_data[idx];
        end
        if (q_rd[idx] == bus.a2) begin
          h2 = 1'b1;
          d2 = q_data[idx];
        end
      end
    end
  end

  assign bus.fwd1_hit  = h1 && (bus.a1 != '0) && !reset;
  assign bus.fwd2_hit  = h2 && (bus.a2 != '0) && !reset;
  assign bus.fwd1_data = bus.fwd1_hit ? d1 : '0;
  assign bus.fwd2_data = bus.fwd2_hit ? d2 : '0;

  assign bus.we    = we_r;
  assign bus.a3    = a3_r;
  assign bus.wd3   = wd3_r;
  assign bus.count = cnt;
  assign bus.empty = (cnt == '0) && !we_r;

`ifdef WBQ_STATS_EN
  logic stall;
  assign stall = (bus.alu_valid && !bus.alu_ready) || (bus.ld_valid && !bus.ld_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stall <= '0;
      stat_hwm   <= '0;
    end else begin
      if (stall && (stat_stall != '1))
        stat_stall <= stat_stall + 32'd1;
      if (cnt_next > stat_hwm)
        stat_hwm <= cnt_next;
    end
  end
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: a queue-based reference model predicts accepts, drains
// and bypass; a negedge monitor compares every DUT output against it.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_queue_if #(.DEPTH(DEPTH)) bus ();

`ifdef WBQ_STATS_EN
  logic [31:0]   stat_stall;
  logic [CW-1:0] stat_hwm;
`endif

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef WBQ_STATS_EN
    ,
    .stat_stall (stat_stall),
    .stat_hwm   (stat_hwm)
`endif
  );

  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model: pending writes in acceptance order, plus the register-file write slot.
  wr_t         mq[$];
  wr_t         exp_q[$];
  bit          m_we;
  wr_t         m_wr;
  int unsigned m_stall;
  int unsigned m_hwm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_we    = 1'b0;
    m_stall = 0;
    m_hwm   = 0;
  endtask

  function automatic bit m_ld_ready();
    return !reset && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_alu_ready();
    return !reset && (mq.size() + 2 <= DEPTH);
  endfunction

  function automatic void m_look(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (reset || a == 5'd0) return;
    if (m_we && m_wr.rd == a) begin
      h = 1'b1;
      d = m_wr.data;
    end
    foreach (mq[i]) begin
      if (mq[i].rd == a) begin
        h = 1'b1;
        d = mq[i].data;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit lr, ar;
    if (reset) begin
      model_clear();
    end else begin
      lr = m_ld_ready();
      ar = m_alu_ready();
      if ((bus.alu_valid && !ar) || (bus.ld_valid && !lr))
        m_stall++;
      m_we = (mq.size() > 0);
      if (m_we)
        m_wr = mq.pop_front();
      if (bus.ld_valid && lr && bus.ld_rd != 5'd0) begin
        mq.push_back({bus.ld_rd, bus.ld_data});
        exp_q.push_back({bus.ld_rd, bus.ld_data});
      end
      if (bus.alu_valid && ar && bus.alu_rd != 5'd0) begin
        mq.push_back({bus.alu_rd, bus.alu_data});
        exp_q.push_back({bus.alu_rd, bus.alu_data});
      end
      if (mq.size() > m_hwm)
        m_hwm = mq.size();
    end
  end

  always @(negedge clk) begin
    logic        h;
    logic [31:0] d;
    wr_t         e;
    check("ld_ready",  32'(bus.ld_ready),  32'(m_ld_ready()));
    check("alu_ready", 32'(bus.alu_ready), 32'(m_alu_ready()));
    check("count",     32'(bus.count),     32'(mq.size()));
    check("empty",     32'(bus.empty),     32'(mq.size() == 0 && !m_we));
    check("we",        32'(bus.we),        32'(m_we));
    if (bus.we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_order: got write a3=%0d with no write expected at %0t", bus.a3, $time);
      end else begin
        e = exp_q.pop_front();
        check("a3",  32'(bus.a3), 32'(e.rd));
        check("wd3", bus.wd3,     e.data);
      end
    end
    m_look(bus.a1, h, d);
    check("fwd1_hit",  32'(bus.fwd1_hit), 32'(h));
    check("fwd1_data", bus.fwd1_data,     d);
    m_look(bus.a2, h, d);
    check("fwd2_hit",  32'(bus.fwd2_hit), 32'(h));
    check("fwd2_data", bus.fwd2_data,     d);
`ifdef WBQ_STATS_EN
    check("stat_stall", stat_stall,       m_stall);
    check("stat_hwm",   32'(stat_hwm),    m_hwm);
`endif
  end

  task automatic drive(input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                       input logic av, input logic [4:0] ard, input logic [31:0] add,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldd;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = add;
    bus.a1        = r1;
    bus.a2        = r2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
    repeat (n) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  initial begin
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.a1        = '0;
    bus.a2        = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // single ALU write with bypass on a1
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1122_3344, 5'd5, 5'd0);
    idle(4, 5'd5, 5'd6);

    // simultaneous load and ALU to the same register: load is older
    drive(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'hBBBB_0000, 5'd7, 5'd7);
    idle(4, 5'd7, 5'd0);

    // writes to x0 are swallowed
    drive(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    idle(3, 5'd0, 5'd0);

    // back-to-back pushes to build occupancy and exercise ready thresholds
    drive(1'b1, 5'd1, 32'h0000_0001, 1'b1, 5'd2, 32'h0000_0002, 5'd1, 5'd2);
    drive(1'b1, 5'd3, 32'h0000_0003, 1'b1, 5'd4, 32'h0000_0004, 5'd3, 5'd4);
    for (int k = 0; k < 5; k++)
      drive(1'b1, 5'(k + 5), 32'(k + 5), 1'b1, 5'd9, 32'h0000_0009, 5'd9, 5'(k + 5));
    idle(6, 5'd4, 5'd9);

    // reset with entries pending
    drive(1'b1, 5'd11, 32'h0B0B_0B0B, 1'b1, 5'd12, 32'h0C0C_0C0C, 5'd11, 5'd12);
    drive(1'b1, 5'd13, 32'h0D0D_0D0D, 1'b1, 5'd14, 32'h0E0E_0E0E, 5'd11, 5'd13);
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_we",    32'(bus.we),       32'd0);
    check("rst_count", 32'(bus.count),    32'd0);
    check("rst_fwd1",  32'(bus.fwd1_hit), 32'd0);
    check("rst_fwd2",  32'(bus.fwd2_hit), 32'd0);
    idle(2, 5'd11, 5'd13);
    reset = 1'b0;
    idle(5, 5'd11, 5'd13);

    // randomized traffic over a small register range to provoke bypass hits
    for (int k = 0; k < 1500; k++)
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    idle(8, 5'd0, 5'd0);
    check("drain_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
